polara_noc_traffic_gen: RTL and testbench

//  Configurable NoC traffic source for chipset-side bring-up of the Polara chip.

---
 rtl/polara_noc_traffic_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_polara_noc_traffic_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/polara_noc_traffic_gen.sv
// polara_noc_traffic_gen: chipset-side NoC traffic source for Polara bring-up.
// A start pulse latches the configuration and sends a burst of packets into one NoC channel.
// Each packet is a header flit followed by payload_len beats. The payload pattern is zero,
// walking-one, a global beat counter, or a 32-bit LFSR replicated across the flit.
// Ports:
//   chipset_clk, chip_rst_n         clock, async active-low reset
//   start, abort                    burst start pulse, sticky stop at next packet boundary
//   noc_sel, mode                   target NoC (1..NUM_NOCS), payload pattern
//   payload_len, msg_type           header length / message type fields
//   burst_len                       packets per burst (0 = run until abort)
//   noc_data_out, noc_val_out       flattened flits and valids (NoC k at slice k-1)
//   noc_rdy_in                      per-NoC ready
//   busy, done, cfg_err, pkt_sent   status: burst active, completion pulse, rejected start, count
module polara_noc_traffic_gen #(
  parameter int unsigned NOC_DATA_WIDTH = 64,
  parameter int unsigned NUM_NOCS       = 3,
  parameter logic [13:0] CHIPID         = 14'b10000000000000,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_0001
) (
  input  logic                                chipset_clk,
  input  logic                                chip_rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [1:0]                          noc_sel,
  input  logic [1:0]                          mode,
  input  logic [7:0]                          payload_len,
  input  logic [7:0]                          msg_type,
  input  logic [7:0]                          burst_len,
  output logic [NUM_NOCS*NOC_DATA_WIDTH-1:0]  noc_data_out,
  output logic [NUM_NOCS-1:0]                 noc_val_out,
  input  logic [NUM_NOCS-1:0]                 noc_rdy_in,
  output logic                                busy,
  output logic                                done,
  output logic                                cfg_err,
  output logic [15:0]                         pkt_sent
);

  localparam int unsigned DW = NOC_DATA_WIDTH;
  localparam int unsigned NW = NUM_NOCS * NOC_DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_GAP, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [1:0]     sel_q, sel_d, mode_q, mode_d;
  logic [7:0]     plen_q, plen_d, mtype_q, mtype_d, blen_q, blen_d;
  logic [7:0]     beat_q, beat_d;
  logic [31:0]    gbeat_q, gbeat_d, lfsr_q, lfsr_d, gap_q, gap_d;
  logic [15:0]    pkt_sent_q, pkt_sent_d;
  logic           abort_q, abort_d;
  logic [NW-1:0]  noc_data_q, noc_data_d;
  logic [NUM_NOCS-1:0] noc_val_q, noc_val_d;
  logic           busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic           xfer_c, abort_seen_c, pkt_end_c, sel_ok_c;
  logic [DW-1:0]  flit_c;

  // Flit content for a given state and beat position.
  function automatic logic [DW-1:0] flit_f(input state_e st, input logic [1:0] md,
                                           input logic [7:0] plen, input logic [7:0] mt,
                                           input logic [7:0] idx, input logic [7:0] b,
                                           input logic [31:0] g, input logic [31:0] lf);
    logic [DW-1:0] f;
    f = '0;
    if (st == S_HEADER) begin
      f[63:0] = {CHIPID, 8'd0, 8'd0, 4'b0010, plen, mt, idx, 6'd0};
    end else if (st == S_PAYLOAD) begin
      case (md)
        2'b01:   f = DW'(1) << (32'(b) % DW);
        2'b10:   f = DW'(g);
        2'b11:   for (int i = 0; i < int'(DW); i++) f[i] = lf[5'(i % 32)];
        default: f = '0;
      endcase
    end
    return f;
  endfunction

  // Exactly one val bit can be high, so any val&rdy overlap is the selected NoC's transfer.
  assign xfer_c       = |(noc_val_q & noc_rdy_in);
  assign abort_seen_c = abort_q | abort;
  assign sel_ok_c     = (noc_sel != 2'd0) && (32'(noc_sel) <= NUM_NOCS);

  // Next-state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    plen_d     = plen_q;
    mtype_d    = mtype_q;
    blen_d     = blen_q;
    beat_d     = beat_q;
    gbeat_d    = gbeat_q;
    lfsr_d     = lfsr_q;
    gap_d      = gap_q;
    pkt_sent_d = pkt_sent_q;
    abort_d    = abort_seen_c;
    cfg_err_d  = 1'b0;
    pkt_end_c  = 1'b0;
    noc_val_d  = '0;
    noc_data_d = '0;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (sel_ok_c) begin
            sel_d      = noc_sel;
            mode_d     = mode;
            plen_d     = payload_len;
            mtype_d    = msg_type;
            blen_d     = burst_len;
            pkt_sent_d = '0;
            lfsr_d     = LFSR_SEED;
            beat_d     = '0;
            gbeat_d    = '0;
            state_d    = S_HEADER;
          end else begin
            cfg_err_d  = 1'b1;
          end
        end
      end
      S_HEADER: begin
        // A pending abort drops an untransferred header; a transferring header always completes.
        if (xfer_c) begin
          if (plen_q == 8'd0) pkt_end_c = 1'b1;
          else                state_d   = S_PAYLOAD;
        end else if (abort_seen_c) begin
          state_d = S_DONE;
        end
      end
      S_PAYLOAD: begin
        if (xfer_c) begin
          beat_d  = beat_q + 8'd1;
          gbeat_d = gbeat_q + 32'd1;
          lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
          if (beat_q == plen_q - 8'd1) pkt_end_c = 1'b1;
        end
      end
      S_GAP: begin
        if (abort_seen_c)       state_d = S_DONE;
        else if (gap_q == '0)   state_d = S_HEADER;
        else                    gap_d   = gap_q - 32'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pkt_end_c) begin
      beat_d     = '0;
      pkt_sent_d = (pkt_sent_q == 16'hFFFF) ? pkt_sent_q : pkt_sent_q + 16'd1;
      if (abort_seen_c || (blen_q != 8'd0 && pkt_sent_d == {8'd0, blen_q})) begin
        state_d = S_DONE;
      end else if (GAP_CYCLES > 0) begin
        state_d = S_GAP;
        gap_d   = 32'(GAP_CYCLES - 1);
      end else begin
        state_d = S_HEADER;
      end
    end

    // Header MSHR carries the index of the packet about to be sent.
    flit_c = flit_f(state_d, mode_d, plen_d, mtype_d, pkt_sent_d[7:0], beat_d, gbeat_d, lfsr_d);
    for (int k = 0; k < int'(NUM_NOCS); k++) begin
      if ((state_d == S_HEADER || state_d == S_PAYLOAD) && sel_d == 2'(k + 1)) begin
        noc_val_d[k]            = 1'b1;
        noc_data_d[k*DW +: DW]  = flit_c;
      end
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge chipset_clk or negedge chip_rst_n) begin
    if (!chip_rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      mode_q     <= '0;
      plen_q     <= '0;
      mtype_q    <= '0;
      blen_q     <= '0;
      beat_q     <= '0;
      gbeat_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      gap_q      <= '0;
      pkt_sent_q <= '0;
      abort_q    <= 1'b0;
      noc_data_q <= '0;
      noc_val_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      plen_q     <= plen_d;
      mtype_q    <= mtype_d;
      blen_q     <= blen_d;
      beat_q     <= beat_d;
      gbeat_q    <= gbeat_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      pkt_sent_q <= pkt_sent_d;
      abort_q    <= abort_d;
      noc_data_q <= noc_data_d;
      noc_val_q  <= noc_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign noc_data_out = noc_data_q;
  assign noc_val_out  = noc_val_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign pkt_sent     = pkt_sent_q;

endmodule

// File: tb/tb_polara_noc_traffic_gen.sv
// Testbench for polara_noc_traffic_gen: bursts are compared flit-by-flit against an expected
// packet stream built from the packet format and pattern rules, plus directed corner cases.
module tb_polara_noc_traffic_gen;

  localparam int unsigned DW  = 64;
  localparam int unsigned NN  = 3;
  localparam int unsigned GAP = 2;
  localparam logic [13:0] CHIPID = 14'b10000000000000;
  localparam logic [31:0] SEED   = 32'hACE1_0001;

  logic              clk;
  logic              rst_n;
  logic              start, abort;
  logic [1:0]        noc_sel, mode;
  logic [7:0]        payload_len, msg_type, burst_len;
  logic [NN*DW-1:0]  noc_data_out;
  logic [NN-1:0]     noc_val_out, noc_rdy_in;
  logic              busy, done, cfg_err;
  logic [15:0]       pkt_sent;

  int errors = 0;
  int checks = 0;

  polara_noc_traffic_gen #(
    .NOC_DATA_WIDTH(DW), .NUM_NOCS(NN), .CHIPID(CHIPID), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .chipset_clk(clk), .chip_rst_n(rst_n), .start(start), .abort(abort),
    .noc_sel(noc_sel), .mode(mode), .payload_len(payload_len), .msg_type(msg_type),
    .burst_len(burst_len), .noc_data_out(noc_data_out), .noc_val_out(noc_val_out),
    .noc_rdy_in(noc_rdy_in), .busy(busy), .done(done), .cfg_err(cfg_err), .pkt_sent(pkt_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] slice(input int k);
    return noc_data_out[k*DW +: DW];
  endfunction

  function automatic logic [63:0] hdr(input logic [7:0] plen, input logic [7:0] mt, input logic [7:0] idx);
    return {CHIPID, 8'd0, 8'd0, 4'b0010, plen, mt, idx, 6'd0};
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  // One burst: build the expected flit stream, then drive/observe at negedges until done.
  task automatic run_burst(input string name, input int sel, input int md, input int plen,
                           input int mt, input int blen, input int npk, input int abort_at,
                           input bit rnd);
    logic [63:0] exp_q[$];
    logic [31:0] lf;
    int g, xfers, cyc, gap_run, si, fpp;
    bit got_done, quiet_ok, hold_ok, status_ok, in_gap, aborted, r;
    lf = SEED; g = 0; fpp = plen + 1; si = sel - 1;
    for (int p = 0; p < npk; p++) begin
      exp_q.push_back(hdr(8'(plen), 8'(mt), 8'(p)));
      for (int b = 0; b < plen; b++) begin
        case (md)
          1:       exp_q.push_back(64'd1 << (b % 64));
          2:       exp_q.push_back(64'(g));
          3:       exp_q.push_back({lf, lf});
          default: exp_q.push_back(64'd0);
        endcase
        lf = lfsr_next(lf);
        g++;
      end
    end
    xfers = 0; cyc = 0; gap_run = 0; got_done = 0; quiet_ok = 1; hold_ok = 1;
    status_ok = 1; in_gap = 0; aborted = 0;
    @(negedge clk);
    noc_sel = 2'(sel); mode = 2'(md); payload_len = 8'(plen); msg_type = 8'(mt);
    burst_len = 8'(blen); start = 1'b1; abort = 1'b0; noc_rdy_in = '1;
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < int'(NN); k++)
        if (k != si && (noc_val_out[k] || slice(k) != '0)) quiet_ok = 0;
      if (cfg_err || !busy) status_ok = 0;
      if (done) begin
        got_done = 1;
        if (noc_val_out != '0) quiet_ok = 0;
      end else begin
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        abort = 1'b0;
        if (abort_at >= 0 && !aborted && xfers == abort_at) begin
          abort = 1'b1;
          aborted = 1;
        end
        if (noc_val_out[si]) begin
          if (in_gap) begin
            chk($sformatf("%s gap", name), 64'(gap_run), 64'(GAP));
            in_gap = 0;
          end
          if (xfers >= exp_q.size()) hold_ok = 0;
          else if (r) begin
            chk($sformatf("%s flit%0d", name, xfers), slice(si), exp_q[xfers]);
            xfers++;
            if (xfers % fpp == 0 && xfers < exp_q.size()) begin
              in_gap = 1;
              gap_run = 0;
            end
          end else if (slice(si) !== exp_q[xfers]) hold_ok = 0;
        end else if (in_gap) gap_run++;
        else if (xfers < exp_q.size()) hold_ok = 0;
        noc_rdy_in = NN'($urandom);
        noc_rdy_in[si] = r;
        // Inputs wander mid-burst and a second start arrives; none of it may matter.
        start = (cyc == 3);
        noc_sel = 2'($urandom); mode = 2'($urandom); payload_len = 8'($urandom);
        msg_type = 8'($urandom); burst_len = 8'($urandom);
      end
    end
    start = 1'b0; abort = 1'b0;
    chk($sformatf("%s done seen", name), 64'(got_done), 64'd1);
    chk($sformatf("%s flit count", name), 64'(xfers), 64'(exp_q.size()));
    chk($sformatf("%s pkt_sent", name), 64'(pkt_sent), 64'(npk));
    chk($sformatf("%s other nocs quiet", name), 64'(quiet_ok), 64'd1);
    chk($sformatf("%s val/data held", name), 64'(hold_ok), 64'd1);
    chk($sformatf("%s busy/cfg_err", name), 64'(status_ok), 64'd1);
    if (!rnd && abort_at < 0)
      chk($sformatf("%s cycles to done", name), 64'(cyc), 64'(exp_q.size() + 1 + (npk - 1) * GAP));
    @(negedge clk);
    chk($sformatf("%s idle after done", name), 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int bl;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; noc_sel = '0; mode = '0;
    payload_len = '0; msg_type = '0; burst_len = '0; noc_rdy_in = '0;
    #12;
    chk("reset val", 64'(noc_val_out), 64'd0);
    chk("reset data", 64'(|noc_data_out), 64'd0);
    chk("reset status", 64'({busy, done, cfg_err, pkt_sent}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_burst("hdr_only", 2, 0, 0, 8'h5A, 1, 1, -1, 0);
    run_burst("walk65", 1, 1, 65, 8'h11, 1, 1, -1, 0);
    run_burst("counter", 3, 2, 4, 8'h22, 3, 3, -1, 1);
    run_burst("lfsr_a", 2, 3, 2, 8'h33, 2, 2, -1, 0);
    run_burst("lfsr_b", 2, 3, 2, 8'h33, 2, 2, -1, 1);
    run_burst("cont_abort", 1, 1, 3, 8'h44, 0, 5, 18, 0);
    run_burst("gap_abort", 3, 2, 3, 8'h55, 0, 1, 4, 1);
    for (int t = 0; t < 4; t++) begin
      bl = $urandom_range(1, 4);
      run_burst($sformatf("rnd%0d", t), $urandom_range(1, 3), $urandom_range(0, 3),
                $urandom_range(0, 6), $urandom_range(0, 255), bl, bl, -1, 1);
    end

    // Bad noc_sel is rejected with a single cfg_err pulse.
    @(negedge clk);
    noc_sel = 2'd0; start = 1'b1; noc_rdy_in = '1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err pulse", 64'({cfg_err, busy, noc_val_out}), 64'b10000);
    @(negedge clk);
    chk("cfg_err clear", 64'({cfg_err, busy}), 64'd0);

    // Abort while the header waits for ready: header dropped, nothing counted.
    @(negedge clk);
    noc_sel = 2'd3; mode = 2'd0; payload_len = 8'd2; burst_len = 8'd1; start = 1'b1; noc_rdy_in = '0;
    @(negedge clk);
    start = 1'b0;
    chk("hdr abort pending", 64'(noc_val_out), 64'b100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("hdr abort done", 64'({done, noc_val_out}), 64'b1000);
    chk("hdr abort pkt_sent", 64'(pkt_sent), 64'd0);
    @(negedge clk);
    chk("hdr abort idle", 64'({busy, done}), 64'd0);

    // Asynchronous reset in the middle of the second packet's payload.
    @(negedge clk);
    noc_sel = 2'd1; mode = 2'd3; payload_len = 8'd10; burst_len = 8'd2; start = 1'b1; noc_rdy_in = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset payload", 64'({noc_val_out[0], pkt_sent}), 64'({1'b1, 16'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("midreset val", 64'(noc_val_out), 64'd0);
    chk("midreset data", 64'(|noc_data_out), 64'd0);
    chk("midreset status", 64'({busy, done, cfg_err, pkt_sent}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst("lfsr_after_reset", 3, 3, 2, 8'h66, 2, 2, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
